word_uart_tx: RTL and testbench
===============================

Name: word_uart_tx

Overview:
- Buffers 32-bit words, splits each into 4 bytes, and serialises each byte as an 8N1 UART frame on a single TX line.
- Three internal stages: a word FIFO, a byte separator with a valid/ready handshake, and a UART transmitter (ready/start handshake).
- Sits between a word-producing datapath and the board UART pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 2.
FIFO_DEPTH, 4, word FIFO entries; power of two, 2..16.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
data_i  in  32  word to transmit.
valid_pulse_i  in  1  one-cycle write strobe for data_i.
full_o  in/out: out  1  FIFO full; writes are dropped while high.
tx_o  out  1  UART serial output; idles high.
busy_o  out  1  high while any word or byte is pending or in flight.

Behaviour:
- Reset (synchronous, active-high) values:
  - tx_o=1, full_o=0, busy_o=0.
  - FIFO empty; separator idle; transmitter idle.
  - Reset mid-frame aborts the frame: tx_o is high after that edge, and all pending words are discarded.
- FIFO write:
  - On an edge where valid_pulse_i=1 and full_o=0, data_i is stored.
  - If full_o=1, the word is silently dropped.
  - A push and a pop on the same edge are both performed.
  - full_o is registered and equals (count==FIFO_DEPTH).
- Separator states: IDLE, LOAD, SEND, WAIT.
  - IDLE: if the FIFO is non-empty, pop the head word into a 32-bit shift holder, clear byte index 0, go to SEND.
  - SEND: present byte[index] to the transmitter with a start strobe while the transmitter's ready=1, then go to WAIT.
  - WAIT: wait for ready to drop and rise again. Then increment the index; after index 3 go to IDLE, otherwise go to SEND.
  - Byte order is least-significant byte first: data[7:0], [15:8], [23:16], [31:24].
- Transmitter states: IDLE, START, DATA, STOP.
  - ready=1 only in IDLE.
  - Start strobe in IDLE latches the byte and goes to START.
  - Frame: tx_o=0 for CLKS_PER_BIT cycles, then 8 data bits LSB first, each for CLKS_PER_BIT cycles, then tx_o=1 for CLKS_PER_BIT cycles, then back to IDLE.
  - A start strobe while not ready is ignored.
- Latency:
  - With FIFO and pipeline empty, a word accepted at edge N drives tx_o low at edge N+3.
  - Gap between consecutive frames is at most 3 clk idle-high cycles after the stop bit.
  - Words are transmitted strictly in acceptance order.
- Capacity:
  - The separator holds one word outside the FIFO, so up to FIFO_DEPTH+1 back-to-back words are accepted from empty.
- busy_o = FIFO non-empty OR separator not IDLE OR transmitter not IDLE.
- Widths: the internal bit counter is 3 bits and the baud counter is clog2(CLKS_PER_BIT) bits. Counters wrap to 0 at the end of each bit or frame.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset held 5 cycles, then idle 20 cycles -> tx_o=1, busy_o=0, full_o=0 throughout.
- Write 0x00001234 -> 4 frames decoded as 0x34, 0x12, 0x00, 0x00. Each frame is 40 clk long (start 0, LSB-first data, stop 1). First start bit at accept edge +3. busy_o falls after the last stop bit.
- Write 0x00001234, 0x00005678, 0x00009ABC with one idle cycle between strobes -> 12 frames in the order 34,12,00,00,78,56,00,00,BC,9A,00,00.
- Strobe 6 consecutive cycles with words 0x11111111..0x66666666 -> full_o rises after the 5th accept. The 6th is dropped. Exactly 20 frames are sent, for words 1..5 only.
- Assert reset during the data bits of the second frame -> tx_o is high after the reset edge and no further frames appear. A new write after reset transmits correctly from byte 0.
- Write 0xFF00A55A -> frames 5A, A5, 00, FF. Check per-bit serialisation of the alternating patterns and the all-zero/all-one bytes.

Source files
------------

// File: rtl/word_uart_tx.sv
// word_uart_tx: buffers 32-bit words, splits each into bytes (LSB first) and sends them as 8N1 frames.
// Pipeline: word FIFO -> byte separator (valid/ready) -> UART transmitter (ready/start).
module word_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_i,
  input  logic        valid_pulse_i,
  output logic        full_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PTR_W1 = PTR_W + 1;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PTR_W:0]   DEPTH_C     = PTR_W1'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_LAST_C = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {SEP_IDLE, SEP_LOAD, SEP_SEND, SEP_WAIT} sep_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [31:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]   count_r, count_next_s;
  logic             full_r, busy_r, tx_r;
  logic             push_s, pop_s, start_s, tx_ready_s, baud_done_s;

  sep_state_t       sep_state_r, sep_next_s;
  logic [31:0]      holder_r;
  logic [1:0]       idx_r;
  logic             seen_low_r;

  tx_state_t        tx_state_r, tx_next_s;
  logic [CNT_W-1:0] baud_r, baud_next_s;
  logic [2:0]       bit_r, bit_next_s;
  logic [7:0]       shreg_r;

  assign push_s      = valid_pulse_i & ~full_r;
  assign tx_ready_s  = (tx_state_r == TX_IDLE);
  assign baud_done_s = (baud_r == BAUD_LAST_C);

  assign full_o = full_r;
  assign busy_o = busy_r;
  assign tx_o   = tx_r;

  // FIFO occupancy after this edge's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + PTR_W1'(1);
      2'b01:   count_next_s = count_r - PTR_W1'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; pointers guard every read so the array needs no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // FIFO pointers and count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= PTR_W1'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_next_s;
    end
  end

  // Separator next state; the head word is popped straight into the holder, so LOAD is never entered
  always_comb begin
    sep_next_s = sep_state_r;
    pop_s      = 1'b0;
    start_s    = 1'b0;
    case (sep_state_r)
      SEP_IDLE: begin
        if (count_r != PTR_W1'(0)) begin
          pop_s      = 1'b1;
          sep_next_s = SEP_SEND;
        end else begin
          sep_next_s = SEP_IDLE;
        end
      end
      SEP_SEND: begin
        if (tx_ready_s) begin
          start_s    = 1'b1;
          sep_next_s = SEP_WAIT;
        end else begin
          sep_next_s = SEP_SEND;
        end
      end
      SEP_WAIT: begin
        if (seen_low_r && tx_ready_s) begin
          sep_next_s = (idx_r == 2'd3) ? SEP_IDLE : SEP_SEND;
        end else begin
          sep_next_s = SEP_WAIT;
        end
      end
      SEP_LOAD: sep_next_s = SEP_IDLE;
      default:  sep_next_s = SEP_IDLE;
    endcase
  end

  // Separator registers: holder shifts right so the current byte is always holder_r[7:0]
  always_ff @(posedge clk) begin
    if (reset) begin
      sep_state_r <= SEP_IDLE;
      holder_r    <= 32'h0000_0000;
      idx_r       <= 2'd0;
      seen_low_r  <= 1'b0;
    end else begin
      sep_state_r <= sep_next_s;
      if (pop_s) begin
        holder_r <= mem_r[rd_ptr_r];
        idx_r    <= 2'd0;
      end else if (sep_state_r == SEP_WAIT && seen_low_r && tx_ready_s) begin
        holder_r <= holder_r >> 8;
        idx_r    <= idx_r + 2'd1;
      end
      if (start_s) begin
        seen_low_r <= 1'b0;
      end else if (sep_state_r == SEP_WAIT && !tx_ready_s) begin
        seen_low_r <= 1'b1;
      end
    end
  end

  // Transmitter next state and baud/bit counters
  always_comb begin
    tx_next_s   = tx_state_r;
    baud_next_s = baud_r;
    bit_next_s  = bit_r;
    case (tx_state_r)
      TX_IDLE: begin
        baud_next_s = CNT_W'(0);
        bit_next_s  = 3'd0;
        if (start_s) tx_next_s = TX_START;
        else         tx_next_s = TX_IDLE;
      end
      TX_START: begin
        if (baud_done_s) begin
          baud_next_s = CNT_W'(0);
          tx_next_s   = TX_DATA;
        end else begin
          baud_next_s = baud_r + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (baud_done_s) begin
          baud_next_s = CNT_W'(0);
          if (bit_r == 3'd7) begin
            bit_next_s = 3'd0;
            tx_next_s  = TX_STOP;
          end else begin
            bit_next_s = bit_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_r + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (baud_done_s) begin
          baud_next_s = CNT_W'(0);
          tx_next_s   = TX_IDLE;
        end else begin
          baud_next_s = baud_r + CNT_W'(1);
        end
      end
      default: begin
        tx_next_s   = TX_IDLE;
        baud_next_s = CNT_W'(0);
        bit_next_s  = 3'd0;
      end
    endcase
  end

  // Transmitter registers; the line value follows the state one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= TX_IDLE;
      baud_r     <= CNT_W'(0);
      bit_r      <= 3'd0;
      shreg_r    <= 8'h00;
      tx_r       <= 1'b1;
    end else begin
      tx_state_r <= tx_next_s;
      baud_r     <= baud_next_s;
      bit_r      <= bit_next_s;
      if (start_s) shreg_r <= holder_r[7:0];
      case (tx_state_r)
        TX_START: tx_r <= 1'b0;
        TX_DATA:  tx_r <= shreg_r[bit_r];
        default:  tx_r <= 1'b1;
      endcase
    end
  end

  // Status outputs registered from the post-edge state of every stage
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      full_r <= (count_next_s == DEPTH_C);
      busy_r <= (count_next_s != PTR_W1'(0)) || (sep_next_s != SEP_IDLE) ||
                (tx_next_s != TX_IDLE);
    end
  end

endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx: decodes the TX line into bytes and compares against a queue of expected bytes.
module tb_word_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_i = 32'h0;
  logic        valid_pulse_i = 1'b0;
  logic        full_o, tx_o, busy_o;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  word_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_pulse_i(valid_pulse_i),
    .full_o(full_o), .tx_o(tx_o), .busy_o(busy_o)
  );

  // Reference: every accepted word contributes its four bytes, least significant first.
  task automatic model_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
  endtask

  task automatic strobe(input logic [31:0] w);
    data_i = w; valid_pulse_i = 1'b1;
    @(negedge clk);
    valid_pulse_i = 1'b0;
  endtask

  // Line decoder: waits (bounded) for a start bit, samples every cycle of every bit.
  task automatic recv_frame(input int limit, output logic [7:0] b, output bit ok,
                            output bit tmo, output int gap);
    logic v;
    b = 8'h00; ok = 1'b1; tmo = 1'b0; gap = 0;
    while (tx_o !== 1'b0 && gap < limit) begin @(negedge clk); gap++; end
    if (tx_o !== 1'b0) begin
      tmo = 1'b1; ok = 1'b0;
    end else begin
      for (int c = 0; c < CPB; c++) begin if (tx_o !== 1'b0) ok = 1'b0; @(negedge clk); end
      for (int k = 0; k < 8; k++) begin
        v = tx_o; b[k] = v;
        for (int c = 0; c < CPB; c++) begin if (tx_o !== v) ok = 1'b0; @(negedge clk); end
      end
      for (int c = 0; c < CPB; c++) begin if (tx_o !== 1'b1) ok = 1'b0; @(negedge clk); end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({tx_o, busy_o, full_o} !== 3'b100) begin
        errors++; $display("FAIL reset_hold tx/busy/full=%b expected 100", {tx_o, busy_o, full_o});
      end
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({tx_o, busy_o, full_o} !== 3'b100) begin
        errors++; $display("FAIL reset_idle tx/busy/full=%b expected 100", {tx_o, busy_o, full_o});
      end
    end
  endtask

  task automatic test_single;
    logic [7:0] b, e; bit ok, tmo; int gap;
    model_word(32'h0000_1234);
    strobe(32'h0000_1234);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_rise busy=%b expected 1", busy_o); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (tx_o !== 1'b1) begin errors++; $display("FAIL single_latency_early cyc %0d tx=%b expected 1", c, tx_o); end
      @(negedge clk);
    end
    checks++;
    if (tx_o !== 1'b0) begin errors++; $display("FAIL single_latency tx=%b expected 0 at accept+3", tx_o); end
    for (int i = 0; i < 4; i++) begin
      recv_frame(100, b, ok, tmo, gap);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL single_frame %0d ok=%0d tmo=%0d expected well-formed", i, ok, tmo); end
      checks++;
      if (b !== e) begin errors++; $display("FAIL single_byte %0d got %h expected %h", i, b, e); end
      if (i > 0) begin
        checks++;
        if (gap > 3) begin errors++; $display("FAIL single_gap %0d gap=%0d expected <=3", i, gap); end
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_fall busy=%b expected 0", busy_o); end
  endtask

  task automatic test_three;
    logic [31:0] w [3];
    logic [7:0] b, e; bit ok, tmo; int gap, n;
    w = '{32'h0000_1234, 32'h0000_5678, 32'h0000_9ABC};
    for (int k = 0; k < 3; k++) model_word(w[k]);
    n = exp_q.size();
    fork
      begin
        for (int k = 0; k < 3; k++) begin strobe(w[k]); if (k < 2) @(negedge clk); end
      end
      begin
        for (int i = 0; i < n; i++) begin
          recv_frame(200, b, ok, tmo, gap);
          e = exp_q.pop_front();
          checks++;
          if (!ok || b !== e) begin
            errors++; $display("FAIL three_byte %0d got %h ok=%0d expected %h", i, b, ok, e);
          end
          if (i > 0) begin
            checks++;
            if (gap > 3) begin errors++; $display("FAIL three_gap %0d gap=%0d expected <=3", i, gap); end
          end
        end
      end
    join
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL three_busy busy=%b expected 0", busy_o); end
  endtask

  task automatic test_capacity;
    logic [7:0] b, e; bit ok, tmo; int gap, n, lows;
    for (int k = 0; k < 5; k++) model_word(32'h1111_1111 * 32'(k + 1));
    n = exp_q.size();
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          data_i = 32'h1111_1111 * 32'(k + 1); valid_pulse_i = 1'b1;
          @(negedge clk);
          if (k == 3) begin
            checks++;
            if (full_o !== 1'b0) begin errors++; $display("FAIL cap_full_early full=%b expected 0", full_o); end
          end
          if (k == 4) begin
            checks++;
            if (full_o !== 1'b1) begin errors++; $display("FAIL cap_full_rise full=%b expected 1", full_o); end
          end
        end
        valid_pulse_i = 1'b0;
      end
      begin
        for (int i = 0; i < n; i++) begin
          recv_frame(200, b, ok, tmo, gap);
          e = exp_q.pop_front();
          checks++;
          if (!ok || b !== e) begin
            errors++; $display("FAIL cap_byte %0d got %h ok=%0d expected %h", i, b, ok, e);
          end
        end
      end
    join
    lows = 0;
    repeat (60) begin @(negedge clk); if (tx_o === 1'b0) lows++; end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL cap_extra_frame low_cycles=%0d expected 0", lows); end
    checks++;
    if ({busy_o, full_o} !== 2'b00) begin errors++; $display("FAIL cap_idle busy/full=%b expected 00", {busy_o, full_o}); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] w;
    logic [7:0] b, e; bit ok, tmo; int gap, t, lows;
    w = $urandom;
    model_word(w);
    strobe(w);
    recv_frame(100, b, ok, tmo, gap);
    e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin errors++; $display("FAIL rst_first_byte got %h ok=%0d expected %h", b, ok, e); end
    t = 0;
    while (tx_o !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (tx_o !== 1'b0) begin errors++; $display("FAIL rst_second_start tx=%b expected 0", tx_o); end
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    checks++;
    if ({tx_o, busy_o, full_o} !== 3'b100) begin
      errors++; $display("FAIL rst_abort tx/busy/full=%b expected 100", {tx_o, busy_o, full_o});
    end
    lows = 0;
    repeat (100) begin @(negedge clk); if (tx_o === 1'b0) lows++; end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL rst_residual low_cycles=%0d expected 0", lows); end
    w = $urandom;
    model_word(w);
    strobe(w);
    for (int i = 0; i < 4; i++) begin
      recv_frame(100, b, ok, tmo, gap);
      e = exp_q.pop_front();
      checks++;
      if (!ok || b !== e) begin errors++; $display("FAIL rst_after_byte %0d got %h ok=%0d expected %h", i, b, ok, e); end
    end
  endtask

  task automatic test_pattern;
    logic [7:0] b, e; bit ok, tmo; int gap;
    model_word(32'hFF00_A55A);
    strobe(32'hFF00_A55A);
    for (int i = 0; i < 4; i++) begin
      recv_frame(100, b, ok, tmo, gap);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL pattern_frame %0d ok=%0d tmo=%0d expected well-formed", i, ok, tmo); end
      checks++;
      if (b !== e) begin errors++; $display("FAIL pattern_byte %0d got %h expected %h", i, b, e); end
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL pattern_busy busy=%b expected 0", busy_o); end
  endtask

  task automatic test_random;
    logic [31:0] w [5];
    int          gaps [5];
    logic [7:0] b, e; bit ok, tmo; int gap, n, nw;
    for (int r = 0; r < 4; r++) begin
      nw = $urandom_range(1, 5);
      for (int k = 0; k < nw; k++) begin
        w[k] = $urandom; gaps[k] = $urandom_range(0, 2);
        model_word(w[k]);
      end
      n = exp_q.size();
      fork
        begin
          for (int k = 0; k < nw; k++) begin
            strobe(w[k]);
            repeat (gaps[k]) @(negedge clk);
          end
        end
        begin
          for (int i = 0; i < n; i++) begin
            recv_frame(200, b, ok, tmo, gap);
            e = exp_q.pop_front();
            checks++;
            if (!ok || b !== e) begin
              errors++; $display("FAIL random_byte r%0d i%0d got %h ok=%0d expected %h", r, i, b, ok, e);
            end
            if (i > 0) begin
              checks++;
              if (gap > 3) begin errors++; $display("FAIL random_gap r%0d i%0d gap=%0d expected <=3", r, i, gap); end
            end
          end
        end
      join
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL random_busy r%0d busy=%b expected 0", r, busy_o); end
      repeat (5) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    repeat (5) @(negedge clk);
    test_three();
    repeat (5) @(negedge clk);
    test_capacity();
    test_reset_midframe();
    repeat (5) @(negedge clk);
    test_pattern();
    repeat (5) @(negedge clk);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
